nand_bus_sequencer: RTL and testbench

// Clocked, parametrised ONFI asynchronous-interface cycle generator. Turns a stream of host ops into

---
 rtl/nand_pkg.sv | 37 +++
 rtl/nand_phase_timer.sv | 19 +
 rtl/nand_bus_sequencer.sv | 172 +++++++++++++++++
 tb/tb_nand_bus_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// nand_pkg: shared op/state encodings, ONFI command opcodes and parameter helpers
// for the NAND bus sequencer.
package nand_pkg;
  typedef enum logic [2:0] {
    OP_CMD     = 3'd0,
    OP_ADDR    = 3'd1,
    OP_DIN     = 3'd2,
    OP_DOUT    = 3'd3,
    OP_WAIT_RB = 3'd4
  } op_t;
  typedef enum logic [3:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_R_PULSE,
    S_R_HOLD,
    S_W_WB,
    S_W_RB,
    S_CE_HOLD
  } state_t;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_READ_ID = 8'h90;
  localparam logic [7:0] CMD_READ1   = 8'h00;
  localparam logic [7:0] CMD_READ2   = 8'h30;
  localparam logic [7:0] CMD_PROG1   = 8'h80;
  localparam logic [7:0] CMD_PROG2   = 8'h10;
  localparam logic [7:0] CMD_ERASE1  = 8'h60;
  localparam logic [7:0] CMD_ERASE2  = 8'hD0;
  localparam logic [7:0] CMD_STATUS  = 8'h70;
  function automatic int at_least1(input int v);
    return v < 1 ? 1 : v;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/nand_phase_timer.sv
// nand_phase_timer: loadable down-counter timing the current bus phase; done
// is high on the last clock of a phase loaded with (length - 1).
module nand_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done = cnt_q == '0;
endmodule

// File: rtl/nand_bus_sequencer.sv
// nand_bus_sequencer: ONFI asynchronous-interface cycle generator turning host ops
// into clock-timed command, address, data-in, data-out and ready/busy bus cycles.
module nand_bus_sequencer
  import nand_pkg::*;
#(
  parameter int  DW      = 8,
  parameter int  NUM_CE  = 1,
  parameter int  T_CLS   = 2,
  parameter int  T_WP    = 2,
  parameter int  T_WH    = 1,
  parameter int  T_CH    = 1,
  parameter int  T_RP    = 3,
  parameter int  T_REH   = 1,
  parameter int  T_WB    = 4,
  parameter int  TIMEOUT = 4096,
  localparam int CSW     = NUM_CE > 1 ? $clog2(NUM_CE) : 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_type,
  input  logic [DW-1:0]     op_data,
  input  logic              op_last,
  input  logic [CSW-1:0]    ce_sel,
  input  logic              wp_en,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [NUM_CE-1:0] nCE,
  output logic              CLE,
  output logic              ALE,
  output logic              nWE,
  output logic              nRE,
  output logic              nWP,
  output logic [DW-1:0]     io_out,
  output logic              io_oe,
  input  logic [DW-1:0]     io_in,
  input  logic              RB
);
  localparam int TW = $clog2(at_least1(max2(max2(max2(T_CLS, T_WP), max2(T_WH, T_CH)),
                                            max2(max2(T_RP, T_REH), max2(T_WB, TIMEOUT))))) + 1;
  localparam logic [TW-1:0] L_CLS = TW'(at_least1(T_CLS) - 1);
  localparam logic [TW-1:0] L_WP  = TW'(at_least1(T_WP) - 1);
  localparam logic [TW-1:0] L_WH  = TW'(at_least1(T_WH) - 1);
  localparam logic [TW-1:0] L_CH  = TW'(at_least1(T_CH) - 1);
  localparam logic [TW-1:0] L_RP  = TW'(at_least1(T_RP) - 1);
  localparam logic [TW-1:0] L_REH = TW'(at_least1(T_REH) - 1);
  localparam logic [TW-1:0] L_WB  = TW'(at_least1(T_WB) - 1);
  localparam logic [TW-1:0] L_TO  = TW'(at_least1(TIMEOUT) - 1);
  state_t              state_q, state_d, fin;
  logic [2:0]          type_q, type_d;
  logic                last_q, last_d, held_q, held_d;
  logic [CSW-1:0]      ce_idx_q, ce_idx_d;
  logic [NUM_CE-1:0]   nce_q, nce_d;
  logic                cle_q, cle_d, ale_q, ale_d, nwe_q, nwe_d, nre_q, nre_d, nwp_q, nwp_d;
  logic                io_oe_q, io_oe_d, op_ready_q, op_ready_d, rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d, timeout_q, timeout_d;
  logic [DW-1:0]       io_out_q, io_out_d, rd_data_q, rd_data_d;
  logic                rb_meta_q, rb_sync_q;
  logic                accept, done, ld, wr_d, is_wr_op, rd_cap;
  logic [TW-1:0]       ld_val;
  nand_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .nRST     (nRST),
    .load     (ld),
    .load_val (ld_val),
    .done     (done)
  );
  always_comb begin
    accept   = op_valid && op_ready_q;
    is_wr_op = op_type inside {OP_CMD, OP_ADDR, OP_DIN};
    fin      = last_q ? S_CE_HOLD : S_IDLE;
    state_d  = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = is_wr_op ? S_W_SETUP : op_type == OP_DOUT ? S_R_PULSE :
                                       op_type == OP_WAIT_RB ? S_W_WB : op_last ? S_CE_HOLD : S_IDLE;
      S_W_SETUP: if (done) state_d = S_W_PULSE;
      S_W_PULSE: if (done) state_d = S_W_HOLD;
      S_W_HOLD:  if (done) state_d = fin;
      S_R_PULSE: if (done) state_d = S_R_HOLD;
      S_R_HOLD:  if (done) state_d = fin;
      S_W_WB:    if (done) state_d = S_W_RB;
      S_W_RB:    if (rb_sync_q || done) state_d = fin;
      S_CE_HOLD: if (done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // every phase change reloads the shared timer with the new phase length
    ld     = state_d != state_q;
    ld_val = state_d == S_W_SETUP ? L_CLS : state_d == S_W_PULSE ? L_WP : state_d == S_W_HOLD ? L_WH :
             state_d == S_R_PULSE ? L_RP : state_d == S_R_HOLD ? L_REH : state_d == S_W_WB ? L_WB :
             state_d == S_W_RB ? L_TO : L_CH;
    type_d     = accept ? op_type : type_q;
    last_d     = accept ? op_last : last_q;
    held_d     = accept || (held_q && !(state_q == S_CE_HOLD && done));
    ce_idx_d   = accept && !held_q ? (int'(ce_sel) < NUM_CE ? ce_sel : '0) : ce_idx_q;
    nce_d      = held_d ? ~(NUM_CE'(1) << ce_idx_d) : '1;
    wr_d       = state_d inside {S_W_SETUP, S_W_PULSE, S_W_HOLD};
    cle_d      = wr_d ? type_d == OP_CMD : state_d == S_CE_HOLD && cle_q;
    ale_d      = wr_d ? type_d == OP_ADDR : state_d == S_CE_HOLD && ale_q;
    nwe_d      = state_d != S_W_PULSE;
    nre_d      = state_d != S_R_PULSE;
    nwp_d      = ~wp_en;
    io_oe_d    = wr_d;
    io_out_d   = accept && is_wr_op ? (op_type == OP_DIN ? op_data : DW'(op_data[7:0])) : io_out_q;
    rd_cap     = state_q == S_R_PULSE && done;
    rd_data_d  = rd_cap ? io_in : rd_data_q;
    rd_valid_d = rd_cap;
    timeout_d  = state_q == S_W_RB && !rb_sync_q && done;
    op_ready_d = state_d == S_IDLE;
    busy_d     = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      last_q     <= 1'b0;
      held_q     <= 1'b0;
      ce_idx_q   <= '0;
      nce_q      <= '1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      nwe_q      <= 1'b1;
      nre_q      <= 1'b1;
      nwp_q      <= 1'b0;
      io_oe_q    <= 1'b0;
      io_out_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      op_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      rb_meta_q  <= 1'b0;
      rb_sync_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      last_q     <= last_d;
      held_q     <= held_d;
      ce_idx_q   <= ce_idx_d;
      nce_q      <= nce_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      nwe_q      <= nwe_d;
      nre_q      <= nre_d;
      nwp_q      <= nwp_d;
      io_oe_q    <= io_oe_d;
      io_out_q   <= io_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      timeout_q  <= timeout_d;
      op_ready_q <= op_ready_d;
      busy_q     <= busy_d;
      rb_meta_q  <= RB;
      rb_sync_q  <= rb_meta_q;
    end
  end
  assign op_ready    = op_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign nCE         = nce_q;
  assign CLE         = cle_q;
  assign ALE         = ale_q;
  assign nWE         = nwe_q;
  assign nRE         = nre_q;
  assign nWP         = nwp_q;
  assign io_out      = io_out_q;
  assign io_oe       = io_oe_q;
endmodule

// File: tb/tb_nand_bus_sequencer.sv
// tb_nand_bus_sequencer: directed op sequences; write/read cycles seen on the bus are
// popped from expectation queues filled when each op is issued.
module tb_nand_bus_sequencer;
  import nand_pkg::*;
  typedef struct packed {
    logic        cle;
    logic        ale;
    logic [15:0] io;
    logic [3:0]  nce;
  } wr_t;
  logic        clk = 1'b0;
  logic        nRST, op_valid, op_ready, op_last, wp_en, rd_valid, busy, timeout_err;
  logic        CLE, ALE, nWE, nRE, nWP, io_oe, RB;
  logic [2:0]  op_type;
  logic [15:0] op_data, rd_data, io_out, io_in;
  logic [1:0]  ce_sel;
  logic [3:0]  nCE;
  int          checks = 0, errors = 0;
  wr_t         wq[$];
  logic [15:0] rq[$];
  int          su_len = 0, wp_len = 0, rp_len = 0, ale_clks = 0, ale_rises = 0, ce_rises = 0;
  logic        rd_oe = 1'b0, ale_prev = 1'b0, held = 1'b0;
  logic [3:0]  nce_prev = 4'hF;
  logic [1:0]  held_ce = 2'd0;

  nand_bus_sequencer #(.DW(16), .NUM_CE(4), .TIMEOUT(64)) dut (
    .clk(clk), .nRST(nRST), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_data(op_data), .op_last(op_last), .ce_sel(ce_sel), .wp_en(wp_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .timeout_err(timeout_err), .nCE(nCE), .CLE(CLE), .ALE(ALE),
    .nWE(nWE), .nRE(nRE), .nWP(nWP), .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .RB(RB)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // expectations come from a small model of which CE the sequence holds
  task automatic issue(input logic [2:0] t, input logic [15:0] d, input logic last, input logic [1:0] ce);
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", op_ready, 1);
    if (!held) begin
      held_ce = ce;
      held = 1'b1;
    end
    if (t <= 3'd2) wq.push_back(wr_t'{t == 3'd0, t == 3'd1, t == 3'd2 ? d : {8'h00, d[7:0]}, ~(4'b0001 << held_ce)});
    if (t == 3'd3) begin
      io_in = d;
      rq.push_back(d);
    end
    if (last) held = 1'b0;
    op_valid = 1'b1;
    op_type = t;
    op_data = d;
    op_last = last;
    ce_sel = ce;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(op_ready && nCE == 4'hF) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, op_ready && nCE == 4'hF, 1);
  endtask

  always @(negedge clk) begin
    if (!nRST) begin
      su_len = 0;
      wp_len = 0;
      rp_len = 0;
      rd_oe = 1'b0;
    end else begin
      if (!nWE) wp_len++;
      else if (wp_len != 0) begin
        check("wr_q_nonempty", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          check("wr_cle", CLE, e.cle);
          check("wr_ale", ALE, e.ale);
          check("wr_io", io_out, e.io);
          check("wr_nce", nCE, e.nce);
          check("wr_setup_clks", su_len, 2);
          check("wr_pulse_clks", wp_len, 2);
        end
        wp_len = 0;
        su_len = 0;
      end else if (io_oe) su_len++;
      else su_len = 0;
      if (!nRE) begin
        rp_len++;
        if (io_oe) rd_oe = 1'b1;
      end
      if (rd_valid) begin
        check("rd_q_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) check("rd_data", rd_data, rq.pop_front());
        check("rd_pulse_clks", rp_len, 3);
        check("rd_oe_low", rd_oe, 0);
        rp_len = 0;
        rd_oe = 1'b0;
      end
      if (ALE) ale_clks++;
      if (ALE && !ale_prev) ale_rises++;
      if (nCE == 4'hF && nce_prev != 4'hF) ce_rises++;
    end
    ale_prev = ALE;
    nce_prev = nCE;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, r0, c0;
    nRST = 1'b0;
    op_valid = 1'b0;
    op_type = 3'd0;
    op_data = 16'h0;
    op_last = 1'b0;
    ce_sel = 2'd0;
    wp_en = 1'b0;
    io_in = 16'h0;
    RB = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_nce", nCE, 4'hF);
    check("rst_ctl", {CLE, ALE, nWE, nRE, nWP, io_oe, op_ready, rd_valid, busy, timeout_err}, 10'b0011000000);
    check("rst_data", {io_out, rd_data}, 32'h0);
    nRST = 1'b1;
    #1 check("rel_ready_low", op_ready, 0);
    @(negedge clk);
    check("rel_ready_high", op_ready, 1);
    check("nwp_off", nWP, 1);

    // single RESET command with CE release
    issue(OP_CMD, {8'h00, CMD_RESET}, 1'b1, 2'd0);
    n = 0;
    while (nWE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_nwe_low", nWE, 0);
    check("t1_cle", CLE, 1);
    n = 0;
    while (!nWE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_nwe_high", nWE, 1);
    @(negedge clk);
    check("t1_ce_hold", nCE, 4'hE);
    @(negedge clk);
    check("t1_ce_release", nCE, 4'hF);
    check("t1_cle_off", CLE, 0);

    // READ setup: CMD 00, five address cycles, CMD 30
    a0 = ale_clks;
    r0 = ale_rises;
    c0 = ce_rises;
    issue(OP_CMD, {8'h00, CMD_READ1}, 1'b0, 2'd0);
    for (int i = 1; i <= 5; i++) issue(OP_ADDR, 16'(i), 1'b0, 2'd0);
    issue(OP_CMD, {8'h00, CMD_READ2}, 1'b1, 2'd0);
    wait_idle("t2_idle");
    check("t2_ale_clks", ale_clks - a0, 25);
    check("t2_ale_pulses", ale_rises - r0, 5);
    check("t2_ce_releases", ce_rises - c0, 1);

    // WAIT_RB released by RB after 50 clks
    RB = 1'b0;
    issue(OP_WAIT_RB, 16'h0, 1'b0, 2'd0);
    repeat (50) @(negedge clk);
    check("t3_busy", {busy, op_ready}, 2'b10);
    RB = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 2 || n > 3) begin
      errors++;
      $display("FAIL t3_rb_ready_latency: got %0d clks, expected 2..3", n);
    end
    check("t3_ce_still_held", nCE, 4'hE);
    issue(3'd5, 16'h0, 1'b1, 2'd0);
    wait_idle("t3_idle");

    // WAIT_RB timeout: T_WB + TIMEOUT clks, seen on the following sample
    RB = 1'b0;
    issue(OP_WAIT_RB, 16'h0, 1'b1, 2'd0);
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_clks", n, 4 + 64 + 1);
    @(negedge clk);
    check("t4_timeout_strobe", timeout_err, 0);
    RB = 1'b1;
    wait_idle("t4_idle");

    // four data-out cycles
    for (int i = 0; i < 4; i++) issue(OP_DOUT, 16'hC3A0 + 16'(i), i == 3, 2'd0);
    wait_idle("t5_idle");
    check("t5_rd_q_empty", rq.size(), 0);

    // CE 2 with write protect asserted; later ce_sel ignored while held
    wp_en = 1'b1;
    @(negedge clk);
    check("t6_nwp", nWP, 0);
    issue(OP_DIN, 16'h1234, 1'b0, 2'd2);
    issue(OP_CMD, {8'hFF, CMD_PROG1}, 1'b1, 2'd1);
    wait_idle("t6_idle");
    wp_en = 1'b0;

    // asynchronous reset in the middle of an nWE pulse
    issue(OP_CMD, {8'h00, CMD_STATUS}, 1'b1, 2'd3);
    n = 0;
    while (nWE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t7_in_pulse", nWE, 0);
    nRST = 1'b0;
    #1;
    check("t7_rst_bus", {nWE, nCE, io_oe, busy}, 7'b1111100);
    wq.delete();
    held = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    #1 check("t7_ready_low", op_ready, 0);
    @(negedge clk);
    check("t7_ready_high", op_ready, 1);

    check("end_wr_q_empty", wq.size(), 0);
    check("end_rd_q_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
